// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: redirect/halt control, loader write port and decode-side flow signals.
// The fault line exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_queue_if #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic            halt;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [XLEN-1:0] imem_wdata;
    logic            next_stalled;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            valid;
    logic            stalled;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault;
`endif

    modport master (
        output halt, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata, next_stalled,
        input  instr, instr_pc, valid, stalled
`ifdef FETCH_MISALIGN_TRAP_EN
        , fault
`endif
    );

    modport slave (
        input  halt, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata, next_stalled,
        output instr, instr_pc, valid, stalled
`ifdef FETCH_MISALIGN_TRAP_EN
        , fault
`endif
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, synchronous instruction memory and a small FIFO toward decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              MEM_DEPTH = 256,
    parameter int              QDEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.slave bus
);
    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int QAW = $clog2(QDEPTH);

    logic [XLEN-1:0] mem_r      [MEM_DEPTH];
    logic [XLEN-1:0] q_instr_r  [QDEPTH];
    logic [XLEN-1:0] q_pc_r     [QDEPTH];
    logic [QAW-1:0]  wr_ptr_r;
    logic [QAW-1:0]  rd_ptr_r;
    logic [QAW:0]    count_r;
    logic [XLEN-1:0] f_pc_r;
    logic [XLEN-1:0] rd_data_r;
    logic [XLEN-1:0] rd_pc_r;
    logic            inflight_r;
    logic            fault_r;

    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic            trap_s;
    logic [XLEN-1:0] target_s;
    logic [QAW+1:0]  occupancy_s;

    // Admission, push/pop and redirect decode
    always_comb begin
        target_s    = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
        // In-flight read reserves a slot so a push can never hit a full FIFO
        occupancy_s = {1'b0, count_r} + {{(QAW+1){1'b0}}, inflight_r};
        pop_s       = (count_r != {(QAW+1){1'b0}}) && !bus.next_stalled;
        push_s      = inflight_r && !bus.redirect;
        issue_s     = !bus.halt && !bus.redirect && !fault_r &&
                      (occupancy_s < (QAW+2)'(QDEPTH));
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_s      = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
        trap_s      = 1'b0;
`endif
    end

    // Loader write port; a same-cycle read sees the old word
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem_r[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // Synchronous memory read and in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 1'b0;
            rd_data_r  <= {XLEN{1'b0}};
            rd_pc_r    <= {XLEN{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                rd_data_r <= mem_r[f_pc_r[AW+1:2]];
                rd_pc_r   <= f_pc_r;
            end
        end
    end

    // Fetch PC and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_pc_r  <= RESET_PC;
            fault_r <= 1'b0;
        end else begin
            if (bus.redirect) begin
                f_pc_r <= target_s;
            end else if (issue_s) begin
                f_pc_r <= f_pc_r + XLEN'(4);
            end
            if (trap_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    // Output FIFO; redirect flushes and wins over push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {QAW{1'b0}};
            rd_ptr_r <= {QAW{1'b0}};
            count_r  <= {(QAW+1){1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr_r[i] <= {XLEN{1'b0}};
                q_pc_r[i]    <= {XLEN{1'b0}};
            end
        end else if (bus.redirect) begin
            wr_ptr_r <= {QAW{1'b0}};
            rd_ptr_r <= {QAW{1'b0}};
            count_r  <= {(QAW+1){1'b0}};
        end else begin
            if (push_s) begin
                q_instr_r[wr_ptr_r] <= rd_data_r;
                q_pc_r[wr_ptr_r]    <= rd_pc_r;
                wr_ptr_r            <= wr_ptr_r + QAW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + QAW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (QAW+1)'(1);
                2'b01:   count_r <= count_r - (QAW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.valid    = (count_r != {(QAW+1){1'b0}});
    assign bus.instr    = q_instr_r[rd_ptr_r];
    assign bus.instr_pc = q_pc_r[rd_ptr_r];
    assign bus.stalled  = (count_r == (QAW+1)'(QDEPTH)) || bus.halt;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fault    = fault_r;
`endif
endmodule
